data_mem_responder: RTL and testbench

- Memory-side responder for the multicycle core's memory interface. Services the core's instType/dataAddress/writeData requests and returns readData.
- Contains a word-organised RAM with byte lanes, LB/LH/LW/LBU/LHU sign and zero extension, and store byte-enables.
- Decodes a small MMIO console region: an 8-bit TX FIFO drained by a valid/ready handshake, plus a status register.
- Sits between the core and the test harness, replacing the behavioural memory model.

---
 rtl/data_mem_responder.sv | 189 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : Byte-lane RAM plus MMIO console TX FIFO serving the multicycle
//               core's memory port. Loads/status reads are registered; console
//               pushes are suppressed when a store request repeats.
// Revision    : 1.1
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter logic [31:0] MEM_BASE     = 32'h8000_0000,
    parameter int          MEM_WORDS    = 4096,
    parameter              INIT_FILE    = "",
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  instType_i,
    input  logic [31:0] dataAddress_i,
    input  logic [31:0] writeData_i,
    output logic [31:0] readData_o,
    output logic        misaligned_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        overflow_o
);

    // Request encoding: bit3 = load, bit2 = unsigned (loads) / store (bit3=0), [1:0] = size.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) << 2;
    localparam logic [PW:0] FULL_CNT  = (PW+1)'(FIFO_DEPTH);

    logic [31:0]   ram [MEM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];

    logic [1:0]    size;
    logic [1:0]    lane;
    logic          is_load;
    logic          is_store;
    logic          misaligned;
    logic [31:0]   offset;
    logic          ram_hit;
    logic          con_data_hit;
    logic          con_stat_hit;
    logic [AW-1:0] word_idx;

    logic [31:0]   src_word;
    logic [31:0]   shifted;
    logic [31:0]   load_val;
    logic [31:0]   status;
    logic [3:0]    byte_en;
    logic [31:0]   wr_rep;
    logic          ram_we;

    logic [3:0]    prev_type;
    logic [31:0]   prev_addr;
    logic [31:0]   prev_data;
    logic          push;
    logic          pop;
    logic          do_push;
    logic          drop;
    logic          empty;
    logic          full;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          overflow;

    assign size         = instType_i[1:0];
    assign lane         = dataAddress_i[1:0];
    assign is_load      = instType_i[3] && (size != 2'b11);
    assign is_store     = !instType_i[3] && instType_i[2] && (size != 2'b11);
    assign misaligned   = (is_load || is_store) &&
                          (((size == SZ_H) && lane[0]) || ((size == SZ_W) && (lane != 2'b00)));
    assign offset       = dataAddress_i - MEM_BASE;
    assign ram_hit      = {1'b0, offset} < RAM_BYTES;
    assign word_idx     = offset[AW+1:2];
    assign con_data_hit = dataAddress_i == CONSOLE_ADDR;
    assign con_stat_hit = dataAddress_i == (CONSOLE_ADDR + 32'd4);

    assign empty    = count == '0;
    assign full     = count == FULL_CNT;
    assign status   = {24'b0, overflow, full, empty, 1'b0, 4'(count)};

    // Load path: pick the source word, shift the addressed lane down, then extend.
    always_comb begin
        src_word = 32'b0;
        if (ram_hit)
            src_word = ram[word_idx];
        else if (con_stat_hit)
            src_word = status;
        shifted  = src_word >> {lane, 3'b000};
        load_val = src_word;
        case (size)
            SZ_B:    load_val = instType_i[2] ? {24'b0, shifted[7:0]}
                                              : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    load_val = instType_i[2] ? {16'b0, shifted[15:0]}
                                              : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = src_word;
        endcase
    end

    always_comb begin
        byte_en = 4'hF;
        wr_rep  = writeData_i;
        case (size)
            SZ_B: begin
                byte_en = 4'b0001 << lane;
                wr_rep  = {4{writeData_i[7:0]}};
            end
            SZ_H: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_rep  = {2{writeData_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign ram_we = is_store && ram_hit && !misaligned;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (byte_en[b]) ram[word_idx][8*b +: 8] <= wr_rep[8*b +: 8];
        end
    end

    // The core presents each store twice; only a changed request may push.
    assign push    = is_store && !misaligned && con_data_hit &&
                     ({instType_i, dataAddress_i, writeData_i} != {prev_type, prev_addr, prev_data});
    assign pop     = tx_valid_o && tx_ready_i;
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk) begin
        if (do_push) fifo[wr_ptr] <= writeData_i[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            prev_type <= 4'b0;
            prev_addr <= 32'b0;
            prev_data <= 32'b0;
        end else begin
            prev_type <= instType_i;
            prev_addr <= dataAddress_i;
            prev_data <= writeData_i;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readData_o   <= 32'b0;
            misaligned_o <= 1'b0;
        end else begin
            misaligned_o <= misaligned;
            if (misaligned)
                readData_o <= 32'b0;
            else if (is_load)
                readData_o <= load_val;
        end
    end

    assign tx_valid_o = !empty;
    assign tx_data_o  = empty ? 8'h00 : fifo[rd_ptr];
    assign overflow_o = overflow;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven directed checks of RAM lanes, extension, misalignment and console FIFO.
`default_nettype none

module tb_data_mem_responder;

  localparam logic [3:0] NOP = 4'b0000;
  localparam logic [3:0] SB  = 4'b0100;
  localparam logic [3:0] SH  = 4'b0101;
  localparam logic [3:0] SW  = 4'b0110;
  localparam logic [3:0] LB  = 4'b1000;
  localparam logic [3:0] LH  = 4'b1001;
  localparam logic [3:0] LW  = 4'b1010;
  localparam logic [3:0] LBU = 4'b1100;
  localparam logic [3:0] LHU = 4'b1101;

  localparam logic [31:0] CON  = 32'h1000_0000;
  localparam logic [31:0] STAT = 32'h1000_0004;

  logic        clk;
  logic        rst_n;
  logic [3:0]  inst_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mis;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        ovf;

  int checks;
  int errors;

  data_mem_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instType_i   (inst_type),
    .dataAddress_i(addr),
    .writeData_i  (wdata),
    .readData_o   (rdata),
    .misaligned_o (mis),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .overflow_o   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  typ;
    logic [31:0] a;
    logic [31:0] wd;
    logic        rdy;
    logic [31:0] e_rd;
    logic        e_mis;
    logic        e_val;
    logic [7:0]  e_dat;
    logic        e_ovf;
  } vec_t;

  vec_t ta[$];
  vec_t tbq[$];

  function automatic vec_t mk(logic [3:0] typ, logic [31:0] a, logic [31:0] wd, logic rdy,
                              logic [31:0] e_rd, logic e_mis, logic e_val, logic [7:0] e_dat,
                              logic e_ovf);
    vec_t v;
    v.typ = typ; v.a = a; v.wd = wd; v.rdy = rdy;
    v.e_rd = e_rd; v.e_mis = e_mis; v.e_val = e_val; v.e_dat = e_dat; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, " readData"},   rdata,           v.e_rd);
    chk({tag, " misaligned"}, {31'b0, mis},    {31'b0, v.e_mis});
    chk({tag, " tx_valid"},   {31'b0, tx_valid}, {31'b0, v.e_val});
    chk({tag, " tx_data"},    {24'b0, tx_data},  {24'b0, v.e_dat});
    chk({tag, " overflow"},   {31'b0, ovf},    {31'b0, v.e_ovf});
  endtask

  task automatic apply(input string tag, input vec_t v);
    inst_type = v.typ;
    addr      = v.a;
    wdata     = v.wd;
    tx_ready  = v.rdy;
    @(posedge clk);
    #1;
    check_outs(tag, v);
  endtask

  initial begin
    vec_t zero_v;
    checks = 0;
    errors = 0;
    rst_n = 1'b0; inst_type = NOP; addr = 32'b0; wdata = 32'b0; tx_ready = 1'b0;

    // Phase A: RAM lanes, extension, misalignment, console suppression and overflow.
    ta.push_back(mk(SW,  32'h8000_0010, 32'hDEAD_BEEF, 0, 32'h0,         0, 0, 8'h00, 0));
    ta.push_back(mk(SB,  32'h8000_0011, 32'h0000_007F, 0, 32'h0,         0, 0, 8'h00, 0));
    ta.push_back(mk(LW,  32'h8000_0010, 32'h0,         0, 32'hDEAD_7FEF, 0, 0, 8'h00, 0));
    ta.push_back(mk(NOP, 32'h0,         32'h0,         0, 32'hDEAD_7FEF, 0, 0, 8'h00, 0));
    ta.push_back(mk(LB,  32'h8000_0013, 32'h0,         0, 32'hFFFF_FFDE, 0, 0, 8'h00, 0));
    ta.push_back(mk(LBU, 32'h8000_0013, 32'h0,         0, 32'h0000_00DE, 0, 0, 8'h00, 0));
    ta.push_back(mk(LH,  32'h8000_0012, 32'h0,         0, 32'hFFFF_DEAD, 0, 0, 8'h00, 0));
    ta.push_back(mk(LHU, 32'h8000_0010, 32'h0,         0, 32'h0000_7FEF, 0, 0, 8'h00, 0));
    ta.push_back(mk(LW,  32'h8000_0002, 32'h0,         0, 32'h0,         1, 0, 8'h00, 0));
    ta.push_back(mk(NOP, 32'h0,         32'h0,         0, 32'h0,         0, 0, 8'h00, 0));
    ta.push_back(mk(SW,  32'h8000_0004, 32'h1122_3344, 0, 32'h0,         0, 0, 8'h00, 0));
    ta.push_back(mk(SH,  32'h8000_0005, 32'h0000_AAAA, 0, 32'h0,         1, 0, 8'h00, 0));
    ta.push_back(mk(LW,  32'h8000_0004, 32'h0,         0, 32'h1122_3344, 0, 0, 8'h00, 0));
    ta.push_back(mk(SH,  32'h8000_0006, 32'h0000_BEEF, 0, 32'h1122_3344, 0, 0, 8'h00, 0));
    ta.push_back(mk(LW,  32'h8000_0004, 32'h0,         0, 32'hBEEF_3344, 0, 0, 8'h00, 0));
    ta.push_back(mk(SW,  32'h8000_3FFC, 32'hCAFE_F00D, 0, 32'hBEEF_3344, 0, 0, 8'h00, 0));
    ta.push_back(mk(LW,  32'h8000_3FFC, 32'h0,         0, 32'hCAFE_F00D, 0, 0, 8'h00, 0));
    ta.push_back(mk(SW,  32'h8000_4000, 32'h1234_5678, 0, 32'hCAFE_F00D, 0, 0, 8'h00, 0));
    ta.push_back(mk(LW,  32'h8000_4000, 32'h0,         0, 32'h0,         0, 0, 8'h00, 0));
    ta.push_back(mk(SB,  CON,           32'h41,        0, 32'h0,         0, 1, 8'h41, 0));
    ta.push_back(mk(SB,  CON,           32'h41,        0, 32'h0,         0, 1, 8'h41, 0));
    ta.push_back(mk(LW,  STAT,          32'h0,         0, 32'h0000_0001, 0, 1, 8'h41, 0));
    ta.push_back(mk(SB,  CON,           32'h42,        0, 32'h0000_0001, 0, 1, 8'h41, 0));
    ta.push_back(mk(NOP, 32'h0,         32'h0,         0, 32'h0000_0001, 0, 1, 8'h41, 0));
    ta.push_back(mk(LW,  STAT,          32'h0,         0, 32'h0000_0002, 0, 1, 8'h41, 0));
    ta.push_back(mk(SB,  CON,           32'h43,        0, 32'h0000_0002, 0, 1, 8'h41, 0));
    ta.push_back(mk(SB,  CON,           32'h44,        0, 32'h0000_0002, 0, 1, 8'h41, 0));
    ta.push_back(mk(SB,  CON,           32'h45,        0, 32'h0000_0002, 0, 1, 8'h41, 1));
    ta.push_back(mk(SB,  CON,           32'h45,        0, 32'h0000_0002, 0, 1, 8'h41, 1));
    ta.push_back(mk(LW,  STAT,          32'h0,         0, 32'h0000_00C4, 0, 1, 8'h41, 1));
    ta.push_back(mk(NOP, 32'h0,         32'h0,         1, 32'h0000_00C4, 0, 1, 8'h42, 1));
    ta.push_back(mk(NOP, 32'h0,         32'h0,         1, 32'h0000_00C4, 0, 1, 8'h43, 1));
    ta.push_back(mk(NOP, 32'h0,         32'h0,         1, 32'h0000_00C4, 0, 1, 8'h44, 1));
    ta.push_back(mk(NOP, 32'h0,         32'h0,         1, 32'h0000_00C4, 0, 0, 8'h00, 1));
    ta.push_back(mk(SB,  CON,           32'h55,        0, 32'h0000_00C4, 0, 1, 8'h55, 1));

    // Phase B (after a reset): push/pop at full and ordering across pointer wrap.
    tbq.push_back(mk(LW,  STAT, 32'h0,  0, 32'h0000_0020, 0, 0, 8'h00, 0));
    tbq.push_back(mk(SB,  CON,  32'h61, 0, 32'h0000_0020, 0, 1, 8'h61, 0));
    tbq.push_back(mk(SB,  CON,  32'h62, 0, 32'h0000_0020, 0, 1, 8'h61, 0));
    tbq.push_back(mk(SB,  CON,  32'h63, 0, 32'h0000_0020, 0, 1, 8'h61, 0));
    tbq.push_back(mk(SB,  CON,  32'h64, 0, 32'h0000_0020, 0, 1, 8'h61, 0));
    tbq.push_back(mk(SB,  CON,  32'h65, 1, 32'h0000_0020, 0, 1, 8'h62, 0));
    tbq.push_back(mk(SB,  CON,  32'h66, 1, 32'h0000_0020, 0, 1, 8'h63, 0));
    tbq.push_back(mk(SB,  CON,  32'h67, 1, 32'h0000_0020, 0, 1, 8'h64, 0));
    tbq.push_back(mk(SB,  CON,  32'h68, 1, 32'h0000_0020, 0, 1, 8'h65, 0));
    tbq.push_back(mk(SB,  CON,  32'h69, 1, 32'h0000_0020, 0, 1, 8'h66, 0));
    tbq.push_back(mk(SB,  CON,  32'h6A, 1, 32'h0000_0020, 0, 1, 8'h67, 0));
    tbq.push_back(mk(LW,  STAT, 32'h0,  0, 32'h0000_0044, 0, 1, 8'h67, 0));
    tbq.push_back(mk(NOP, 32'h0, 32'h0, 1, 32'h0000_0044, 0, 1, 8'h68, 0));
    tbq.push_back(mk(NOP, 32'h0, 32'h0, 1, 32'h0000_0044, 0, 1, 8'h69, 0));
    tbq.push_back(mk(NOP, 32'h0, 32'h0, 1, 32'h0000_0044, 0, 1, 8'h6A, 0));
    tbq.push_back(mk(NOP, 32'h0, 32'h0, 1, 32'h0000_0044, 0, 0, 8'h00, 0));

    zero_v = mk(NOP, 32'h0, 32'h0, 0, 32'h0, 0, 0, 8'h00, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", zero_v);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (ta[i]) apply($sformatf("A%0d", i), ta[i]);

    // Asynchronous reset while a console store is still being presented.
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", zero_v);
    @(posedge clk);
    @(negedge clk);
    inst_type = NOP;
    addr      = 32'h0;
    wdata     = 32'h0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    check_outs("post_reset", zero_v);

    foreach (tbq[i]) apply($sformatf("B%0d", i), tbq[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
